// File: rtl/operand_loader_pkg.sv
// Shared parameters and types for the operand loader and its operand banks.
package operand_loader_pkg;

   localparam int N      = 4;
   localparam int LOG_N  = $clog2(N);
   localparam int DATA_W = 16;

   // Index of the last diagonal beat of a stream.
   localparam int LAST_T = 2 * N - 2;

   typedef logic [DATA_W-1:0]        data_t;
   typedef logic [N-1:0][DATA_W-1:0] row_t;

   typedef enum logic [1:0] {
      S_LOAD_A,
      S_LOAD_B,
      S_FULL,
      S_STREAM
   } loader_state_t;

endpackage

// File: rtl/operand_loader_bank.sv
// operand_bank: N x N operand storage with a row write port and a combinational
// skewed-diagonal read. COL_MAJOR=0 gives A-style lanes (lane i reads
// row i, column t-i); COL_MAJOR=1 gives B-style lanes (lane j reads row t-j,
// column j). Lanes whose index falls outside 0..N-1 read as zero.
module operand_bank
   import operand_loader_pkg::*;
#(
   parameter bit COL_MAJOR = 1'b0
) (
   input  logic             clk_i,
   input  logic             we,
   input  logic [LOG_N-1:0] row_idx,
   input  row_t             row_data,
   input  logic [LOG_N:0]   t,
   output row_t             diag
);

   localparam logic signed [LOG_N+1:0] ZERO_S = '0;
   localparam logic signed [LOG_N+1:0] N_S    = (LOG_N+2)'(N);

   data_t mem_reg [N][N];

   // Capture a whole row on a write strobe; contents are never reset.
   always_ff @(posedge clk_i) begin
      if (we) begin
         for (int j = 0; j < N; j++) begin
            mem_reg[row_idx][j] <= row_data[j];
         end
      end
   end

   for (genvar gi = 0; gi < N; gi++) begin : g_lane
      logic signed [LOG_N+1:0] diff;
      logic [LOG_N-1:0]        idx;
      logic                    in_range;

      // One extra sign bit keeps t-gi from aliasing into a valid index.
      assign diff     = $signed({1'b0, t}) - $signed((LOG_N+2)'(gi));
      assign in_range = (diff >= ZERO_S) && (diff < N_S);
      assign idx      = diff[LOG_N-1:0];

      if (COL_MAJOR) begin : g_col
         assign diag[gi] = in_range ? mem_reg[idx][gi] : '0;
      end else begin : g_row
         assign diag[gi] = in_range ? mem_reg[gi][idx] : '0;
      end
   end

endmodule

// File: rtl/operand_loader.sv
// operand_loader: buffers one A and one B operand (row by row over valid/ready),
// raises load_ready_o when both are held, and on start_i streams 2N-1 skewed
// diagonal beats into the PE array edges before returning to loading.
// Optional macro OPERAND_LOADER_STATS_EN enables a saturating count of
// completed streams on stream_count_o; otherwise that port is tied to zero.
module operand_loader
   import operand_loader_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  row_t        in_row_i,
   output logic        load_ready_o,
   input  logic        start_i,
   output logic        feed_valid_o,
   output row_t        a_feed_o,
   output row_t        b_feed_o,
   output logic        done_o,
   output logic [15:0] stream_count_o
);

   loader_state_t    state_reg, state_next;
   logic [LOG_N-1:0] row_cnt_reg, row_cnt_next;
   logic [LOG_N:0]   t_reg, t_next;

   logic in_ready_reg, in_ready_next;
   logic load_ready_reg, load_ready_next;
   logic feed_valid_reg, feed_valid_next;
   logic done_reg, done_next;
   row_t a_feed_reg, a_feed_next;
   row_t b_feed_reg, b_feed_next;

   row_t a_diag, b_diag;
   logic xfer, we_a, we_b;

   // in_ready_reg mirrors the current state, so no path from in_valid_i exists.
   assign xfer = in_valid_i && in_ready_reg;
   assign we_a = xfer && (state_reg == S_LOAD_A);
   assign we_b = xfer && (state_reg == S_LOAD_B);

   // Banks are read with the next beat index so the registered feeds line up.
   operand_bank #(.COL_MAJOR(1'b0)) u_bank_a (
      .clk_i    (clk_i),
      .we       (we_a),
      .row_idx  (row_cnt_reg),
      .row_data (in_row_i),
      .t        (t_next),
      .diag     (a_diag)
   );

   operand_bank #(.COL_MAJOR(1'b1)) u_bank_b (
      .clk_i    (clk_i),
      .we       (we_b),
      .row_idx  (row_cnt_reg),
      .row_data (in_row_i),
      .t        (t_next),
      .diag     (b_diag)
   );

   // State, counters and registered outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg      <= S_LOAD_A;
         row_cnt_reg    <= '0;
         t_reg          <= '0;
         in_ready_reg   <= 1'b1;
         load_ready_reg <= 1'b0;
         feed_valid_reg <= 1'b0;
         done_reg       <= 1'b0;
         a_feed_reg     <= '0;
         b_feed_reg     <= '0;
      end else begin
         state_reg      <= state_next;
         row_cnt_reg    <= row_cnt_next;
         t_reg          <= t_next;
         in_ready_reg   <= in_ready_next;
         load_ready_reg <= load_ready_next;
         feed_valid_reg <= feed_valid_next;
         done_reg       <= done_next;
         a_feed_reg     <= a_feed_next;
         b_feed_reg     <= b_feed_next;
      end
   end

   // Next-state logic: row counting while loading, beat counting while streaming.
   always_comb begin
      state_next   = state_reg;
      row_cnt_next = row_cnt_reg;
      t_next       = t_reg;
      case (state_reg)
         S_LOAD_A: begin
            if (xfer) begin
               row_cnt_next = row_cnt_reg + 1'b1;
               if (row_cnt_reg == LOG_N'(N - 1)) begin
                  state_next = S_LOAD_B;
               end
            end
         end
         S_LOAD_B: begin
            if (xfer) begin
               row_cnt_next = row_cnt_reg + 1'b1;
               if (row_cnt_reg == LOG_N'(N - 1)) begin
                  state_next = S_FULL;
               end
            end
         end
         S_FULL: begin
            if (start_i) begin
               state_next = S_STREAM;
               t_next     = '0;
            end
         end
         S_STREAM: begin
            if (t_reg == (LOG_N+1)'(LAST_T)) begin
               state_next = S_LOAD_A;
               t_next     = '0;
            end else begin
               t_next = t_reg + 1'b1;
            end
         end
         default: begin
            state_next = S_LOAD_A;
         end
      endcase
   end

   // Output decode from the upcoming state; feeds are zero outside streaming.
   always_comb begin
      in_ready_next   = (state_next == S_LOAD_A) || (state_next == S_LOAD_B);
      load_ready_next = (state_next == S_FULL);
      feed_valid_next = (state_next == S_STREAM);
      done_next       = (state_next == S_STREAM) && (t_next == (LOG_N+1)'(LAST_T));
      a_feed_next     = '0;
      b_feed_next     = '0;
      if (state_next == S_STREAM) begin
         a_feed_next = a_diag;
         b_feed_next = b_diag;
      end
   end

   assign in_ready_o   = in_ready_reg;
   assign load_ready_o = load_ready_reg;
   assign feed_valid_o = feed_valid_reg;
   assign done_o       = done_reg;
   assign a_feed_o     = a_feed_reg;
   assign b_feed_o     = b_feed_reg;

`ifdef OPERAND_LOADER_STATS_EN
   logic [15:0] stream_count_reg;

   // Saturating count of completed streams, bumped once per done pulse.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stream_count_reg <= '0;
      end else if (done_reg && (stream_count_reg != 16'hFFFF)) begin
         stream_count_reg <= stream_count_reg + 16'd1;
      end
   end

   assign stream_count_o = stream_count_reg;
`else
   assign stream_count_o = '0;
`endif

endmodule

// File: doc/operand_loader.md
Name: operand_loader

Overview:
- Upstream neighbour of the array controller. Buffers one N x N A operand and one N x N B operand, arriving row by row over a valid/ready stream.
- Asserts load_ready_o, which drives the controller's ready_i, once both operands are held.
- On start_i it streams skewed diagonals into the PE array edges for 2N-1 cycles, then returns to loading.

Parameters:
- N, pkg::N (4): array dimension. Must be a power of two and at least 2.
- DATA_W, pkg::DATA_W (16): operand element width in bits.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- in_valid_i  in  1  input row valid
- in_ready_o  out  1  loader can accept a row
- in_row_i  in  [N][DATA_W]  one operand row; element j is column j
- load_ready_o  out  1  both operands buffered; connects to controller ready_i
- start_i  in  1  single-cycle pulse from controller to begin streaming
- feed_valid_o  out  1  feed outputs carry a valid diagonal beat
- a_feed_o  out  [N][DATA_W]  left-edge values, one per array row
- b_feed_o  out  [N][DATA_W]  top-edge values, one per array column
- done_o  out  1  pulses with the final feed beat
- stream_count_o  out  16  completed streams (see Optional Feature)

Behaviour:
- Reset (rst_i sampled high at a clock edge):
  - state S_LOAD_A; row counter 0; beat counter 0.
  - Output values: in_ready_o=1, load_ready_o=0, feed_valid_o=0, done_o=0, a_feed_o=0, b_feed_o=0, stream_count_o=0.
  - Buffers are not cleared; their contents are never observable because the feed outputs are gated.
- States:
  - S_LOAD_A: a transfer on in_valid_i && in_ready_o writes A[row_cnt] and increments row_cnt. After beat N-1: row_cnt=0, go to S_LOAD_B.
  - S_LOAD_B: same, writing B[row_cnt]. After beat N-1 go to S_FULL.
  - S_FULL: in_ready_o=0, load_ready_o=1. start_i=1 moves to S_STREAM with t=0.
  - S_STREAM: t counts 0..2N-2. After t=2N-2 go to S_LOAD_A.
- in_ready_o is a registered function of state. It is 1 only in S_LOAD_A and S_LOAD_B, with no combinational path from in_valid_i.
- start_i is ignored in every state except S_FULL. A start_i coinciding with the last B beat is ignored.
- Feed outputs are registered. start_i seen at edge k makes beat t=0 visible in cycle k+1, and beat t is visible in cycle k+1+t.
- During S_STREAM: feed_valid_o=1.
  - a_feed_o[i] = A[i][t-i] when 0 <= t-i < N, else 0.
  - b_feed_o[j] = B[t-j][j] when 0 <= t-j < N, else 0.
- done_o=1 only together with beat t=2N-2. In the following cycle in_ready_o=1 and feed outputs are 0.
- Outside S_STREAM, a_feed_o, b_feed_o and feed_valid_o are 0.
- Widths:
  - row_cnt is LOG_N bits and wraps naturally at N.
  - t is LOG_N+1 bits and never exceeds 2N-2.
  - Index arithmetic t-i uses LOG_N+2-bit signed compares, so no wrap aliasing occurs.
- Reset mid-load or mid-stream aborts immediately: the next cycle shows the full reset output values, and no done_o is produced.
- in_valid_i while in_ready_o=0: no transfer; the row is held by the producer.

Optional Feature:
- Macro: OPERAND_LOADER_STATS_EN.
- Defined: stream_count_o increments on every done_o, saturates at 16'hFFFF, and is cleared by reset.
- Undefined: stream_count_o is tied to 0, no counter flops are synthesized, and the port list is unchanged.

Decomposition:
- pkg additions:
  - DATA_W.
  - data_t (logic [DATA_W-1:0]).
  - loader_state_t enum {S_LOAD_A, S_LOAD_B, S_FULL, S_STREAM}.
  - Reuses the existing N and LOG_N.
- One sub-module, operand_bank, instantiated twice:
  - N x N register storage.
  - Row write port (we, row index, row data).
  - Combinational diagonal read given t; selects row-major for A, column-major for B via a parameter, zero outside range.
- FSM, counters and output registers live in operand_loader.

Test Plan:
1. Reset: assert rst_i for 2 cycles mid-traffic -> in_ready_o=1, load_ready_o=0, feed_valid_o=0, all feeds 0, stream_count_o=0.
2. N=4, A[i][j]=16*i+j+1, B[i][j]=16*i+j+0x81, 8 back-to-back beats -> load_ready_o=1 and in_ready_o=0 on the cycle after beat 8; a 9th in_valid_i is not accepted.
3. Continue from 2, pulse start_i:
   - 7 beats with feed_valid_o=1.
   - t=0: a_feed=[0x01,0,0,0].
   - t=3: a_feed=[0x04,0x13,0x22,0x31], b_feed=[0xB1,0xA2,0x93,0x84].
   - t=6: a_feed=[0,0,0,0x34] with done_o=1.
   - Next cycle in_ready_o=1.
4. Backpressure: in_valid_i toggled randomly over 8 rows -> buffer contents identical to scenario 2; start_i pulsed during S_LOAD_B is ignored, with no feed_valid_o.
5. Reset asserted at stream beat t=2 -> next cycle feed_valid_o=0, done_o never pulses, in_ready_o=1; a fresh load and stream then complete correctly.
6. With OPERAND_LOADER_STATS_EN, 3 full load/stream cycles -> stream_count_o=3. Without the macro -> stream_count_o stays 0.
